// File: rtl/fp_operand_unpack.sv
// -----------------------------------------------------------------------------
// fp_operand_unpack
//
// Front end of the divide/sqrt datapath. It takes a packed operand pair, splits
// each operand into sign, biased exponent and mantissa with the hidden bit
// restored, and classifies it. Operand combinations whose result is known up
// front (NaN, infinity, zero, invalid operations) are resolved here, so the
// iterative core and the exponent logic only see finite nonzero work.
//
// Two registered stages with valid/ready handshaking on both sides:
//   S1 holds the raw operands; S2 holds the classified, unpacked fields.
// Throughput is one pair per cycle. Latency is two cycles from acceptance.
//
// Ports
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   in_valid/in_ready input handshake; in_ready is combinational from out_ready
//   in_op             00 divide a/b, 01 sqrt(a), 10/11 reserved
//   in_a, in_b        packed operands {sign, exp, frac}
//   out_valid/ready   output handshake; outputs hold while stalled
//   out_op            op passthrough
//   out_sign          result sign (a^b for divide, a for sqrt)
//   out_ea, out_eb    biased exponents (subnormals report 1)
//   out_ma, out_mb    mantissas with hidden bit
//   out_special       result resolved here; datapath must bypass iteration
//   out_special_res   packed special result, zero when out_special=0
//   out_invalid       invalid-operation flag
//   out_divzero       divide-by-zero flag
// -----------------------------------------------------------------------------
module fp_operand_unpack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_op,
  output logic                   out_sign,
  output logic [EXP_W-1:0]       out_ea,
  output logic [EXP_W-1:0]       out_eb,
  output logic [MAN_W:0]         out_ma,
  output logic [MAN_W:0]         out_mb,
  output logic                   out_special,
  output logic [EXP_W+MAN_W:0]   out_special_res,
  output logic                   out_invalid,
  output logic                   out_divzero
);

  localparam int W = EXP_W + MAN_W + 1;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_SQRT = 2'b01,
    OP_RSV2 = 2'b10,
    OP_RSV3 = 2'b11
  } op_e;

  typedef struct packed {
    logic zero;
    logic sub;
    logic inf;
    logic nan;
  } fp_class_t;

  typedef struct packed {
    op_e              op;
    logic             sign;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [MAN_W:0]   ma;
    logic [MAN_W:0]   mb;
    logic             special;
    logic [W-1:0]     res;
    logic             invalid;
    logic             divzero;
  } s2_t;

  function automatic fp_class_t classify(input logic [EXP_W-1:0] e,
                                         input logic [MAN_W-1:0] f);
    fp_class_t c;
    c.zero = (e == '0) && (f == '0);
    c.sub  = (e == '0) && (f != '0);
    c.inf  = (e == '1) && (f == '0);
    c.nan  = (e == '1) && (f != '0);
    return c;
  endfunction

  // Subnormals take exponent 1 with a zero hidden bit, matching the scale of
  // the smallest normal; normalization is left to the downstream datapath.
  function automatic logic [EXP_W-1:0] unpack_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? {{(EXP_W-1){1'b0}}, 1'b1} : e;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic         s1_valid_q, s1_valid_d;
  op_e          s1_op_q,    s1_op_d;
  logic [W-1:0] s1_a_q,     s1_a_d;
  logic [W-1:0] s1_b_q,     s1_b_d;
  logic         s2_valid_q, s2_valid_d;
  s2_t          s2_q,       s2_d;

  // ---------------------------------------------------------------------------
  // Handshake, classification and next-state
  // ---------------------------------------------------------------------------
  logic             s2_adv;
  logic             s1_adv;
  logic             sign_a, sign_b, res_sign;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  fp_class_t        cls_a, cls_b;
  s2_t              s2_new;

  // NOTE: always_comb uses blocking assignments and gives every target a
  // default first, so no path can leave a value unassigned and infer a latch.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_adv;
    in_ready = !s1_valid_q || s2_adv;

    sign_a = s1_a_q[W-1];
    sign_b = s1_b_q[W-1];
    exp_a  = s1_a_q[W-2:MAN_W];
    exp_b  = s1_b_q[W-2:MAN_W];
    frac_a = s1_a_q[MAN_W-1:0];
    frac_b = s1_b_q[MAN_W-1:0];
    cls_a  = classify(exp_a, frac_a);
    cls_b  = classify(exp_b, frac_b);

    res_sign = (s1_op_q == OP_DIV) ? (sign_a ^ sign_b) : sign_a;

    s2_new         = '0;
    s2_new.op      = s1_op_q;
    s2_new.sign    = res_sign;
    s2_new.ea      = unpack_exp(exp_a);
    s2_new.eb      = unpack_exp(exp_b);
    s2_new.ma      = {exp_a != '0, frac_a};
    s2_new.mb      = {exp_b != '0, frac_b};

    unique case (s1_op_q)
      OP_DIV: begin
        // Priority order matters: NaN/indeterminate forms first, then x/0
        // for finite x, then inf/finite, then results that collapse to zero.
        if (cls_a.nan || cls_b.nan || (cls_a.zero && cls_b.zero) ||
            (cls_a.inf && cls_b.inf)) begin
          s2_new.special = 1'b1;
          s2_new.res     = QNAN;
          s2_new.invalid = 1'b1;
        end else if (cls_b.zero && !cls_a.inf) begin
          s2_new.special = 1'b1;
          s2_new.res     = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          s2_new.divzero = 1'b1;
        end else if (cls_a.inf) begin
          s2_new.special = 1'b1;
          s2_new.res     = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls_a.zero || cls_b.inf) begin
          s2_new.special = 1'b1;
          s2_new.res     = {res_sign, {(W-1){1'b0}}};
        end
      end
      OP_SQRT: begin
        if (cls_a.nan || (sign_a && !cls_a.zero)) begin
          s2_new.special = 1'b1;
          s2_new.res     = QNAN;
          s2_new.invalid = 1'b1;
        end else if (cls_a.zero) begin
          s2_new.special = 1'b1;
          s2_new.res     = {sign_a, {(W-1){1'b0}}};
        end else if (cls_a.inf) begin
          s2_new.special = 1'b1;
          s2_new.res     = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
      end
      default: begin
        s2_new.special = 1'b1;
        s2_new.res     = QNAN;
        s2_new.invalid = 1'b1;
      end
    endcase

    // S1: when in_ready, S1 is either empty or draining into S2 this cycle,
    // so its next occupancy is simply whether a new pair arrives.
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = op_e'(in_op);
        s1_a_d  = in_a;
        s1_b_d  = in_b;
      end
    end

    // S2 only reloads on s1_adv so stalled or idle outputs keep their values.
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_adv) begin
        s2_d = s2_new;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: data registers are reset along with the valid bits because every
  // data output must read zero straight out of reset, not just out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_DIV;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid       = s2_valid_q;
  assign out_op          = s2_q.op;
  assign out_sign        = s2_q.sign;
  assign out_ea          = s2_q.ea;
  assign out_eb          = s2_q.eb;
  assign out_ma          = s2_q.ma;
  assign out_mb          = s2_q.mb;
  assign out_special     = s2_q.special;
  assign out_special_res = s2_q.res;
  assign out_invalid     = s2_q.invalid;
  assign out_divzero     = s2_q.divzero;

endmodule

// File: tb/tb_fp_operand_unpack.sv
// -----------------------------------------------------------------------------
// tb_fp_operand_unpack
//
// Directed bench for fp_operand_unpack (EXP_W=8, MAN_W=23, binary32 layout).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fp_operand_unpack;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_op;
  logic        out_sign;
  logic [7:0]  out_ea;
  logic [7:0]  out_eb;
  logic [23:0] out_ma;
  logic [23:0] out_mb;
  logic        out_special;
  logic [31:0] out_special_res;
  logic        out_invalid;
  logic        out_divzero;

  int total  = 0;
  int passed = 0;

  fp_operand_unpack #(.EXP_W(8), .MAN_W(23)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_op           (in_op),
    .in_a            (in_a),
    .in_b            (in_b),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_op          (out_op),
    .out_sign        (out_sign),
    .out_ea          (out_ea),
    .out_eb          (out_eb),
    .out_ma          (out_ma),
    .out_mb          (out_mb),
    .out_special     (out_special),
    .out_special_res (out_special_res),
    .out_invalid     (out_invalid),
    .out_divzero     (out_divzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one pair at a falling edge and waits (bounded) for out_valid.
  // lat is the number of falling edges from presenting to out_valid; a
  // timeout leaves lat at 8.
  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_a      = 32'h0;
    in_b      = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset out_valid got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset in_ready got %b want 1", in_ready); else passed++;
    total++; if ({out_ea, out_eb, out_ma, out_mb} !== 64'h0) $display("FAIL reset fields got %h want 0", {out_ea, out_eb, out_ma, out_mb}); else passed++;
    total++; if ({out_special, out_special_res, out_invalid, out_divzero, out_sign, out_op} !== 37'h0) $display("FAIL reset flags got %h want 0", {out_special, out_special_res, out_invalid, out_divzero, out_sign, out_op}); else passed++;
  endtask

  task automatic test_divide_normal();
    int lat;
    @(negedge clk);
    issue(2'b00, 32'h40C00000, 32'h40000000, lat);
    total++; if (lat !== 2) $display("FAIL div_norm latency got %0d want 2", lat); else passed++;
    total++; if (out_ea !== 8'h81) $display("FAIL div_norm ea got %h want 81", out_ea); else passed++;
    total++; if (out_eb !== 8'h80) $display("FAIL div_norm eb got %h want 80", out_eb); else passed++;
    total++; if (out_ma !== 24'hC00000) $display("FAIL div_norm ma got %h want c00000", out_ma); else passed++;
    total++; if (out_mb !== 24'h800000) $display("FAIL div_norm mb got %h want 800000", out_mb); else passed++;
    total++; if (out_sign !== 1'b0) $display("FAIL div_norm sign got %b want 0", out_sign); else passed++;
    total++; if (out_special !== 1'b0 || out_special_res !== 32'h0) $display("FAIL div_norm special got %b/%h want 0/0", out_special, out_special_res); else passed++;
    total++; if (out_invalid !== 1'b0 || out_divzero !== 1'b0) $display("FAIL div_norm flags got %b%b want 00", out_invalid, out_divzero); else passed++;
    total++; if (out_op !== 2'b00) $display("FAIL div_norm op got %b want 00", out_op); else passed++;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL div_norm drain got %b want 0", out_valid); else passed++;
  endtask

  // Special-case table: op, a, b, expected special, result, invalid, divzero.
  task automatic test_specials();
    logic [1:0]  t_op  [11];
    logic [31:0] t_a   [11];
    logic [31:0] t_b   [11];
    logic        t_sp  [11];
    logic [31:0] t_res [11];
    logic        t_inv [11];
    logic        t_dz  [11];
    int lat;
    // divide by -0
    t_op[0]=2'b00;  t_a[0]=32'h3F800000;  t_b[0]=32'h80000000;  t_sp[0]=1; t_res[0]=32'hFF800000;  t_inv[0]=0; t_dz[0]=1;
    // 0/0
    t_op[1]=2'b00;  t_a[1]=32'h00000000;  t_b[1]=32'h00000000;  t_sp[1]=1; t_res[1]=32'h7FC00000;  t_inv[1]=1; t_dz[1]=0;
    // inf/inf
    t_op[2]=2'b00;  t_a[2]=32'h7F800000;  t_b[2]=32'h7F800000;  t_sp[2]=1; t_res[2]=32'h7FC00000;  t_inv[2]=1; t_dz[2]=0;
    // NaN/1
    t_op[3]=2'b00;  t_a[3]=32'h7F800001;  t_b[3]=32'h3F800000;  t_sp[3]=1; t_res[3]=32'h7FC00000;  t_inv[3]=1; t_dz[3]=0;
    // inf/-2 -> -inf, no divzero
    t_op[4]=2'b00;  t_a[4]=32'h7F800000;  t_b[4]=32'hC0000000;  t_sp[4]=1; t_res[4]=32'hFF800000;  t_inv[4]=0; t_dz[4]=0;
    // inf/0 is inf/finite, not divzero
    t_op[5]=2'b00;  t_a[5]=32'hFF800000;  t_b[5]=32'h00000000;  t_sp[5]=1; t_res[5]=32'hFF800000;  t_inv[5]=0; t_dz[5]=0;
    // -0/2 -> -0 ; 2/inf -> +0 folded into the -3/-inf row below
    t_op[6]=2'b00;  t_a[6]=32'h80000000;  t_b[6]=32'h40000000;  t_sp[6]=1; t_res[6]=32'h80000000;  t_inv[6]=0; t_dz[6]=0;
    t_op[7]=2'b00;  t_a[7]=32'hC0400000;  t_b[7]=32'hFF800000;  t_sp[7]=1; t_res[7]=32'h00000000;  t_inv[7]=0; t_dz[7]=0;
    // sqrt(-4), sqrt(-0), sqrt(+inf)
    t_op[8]=2'b01;  t_a[8]=32'hC0800000;  t_b[8]=32'h12345678;  t_sp[8]=1; t_res[8]=32'h7FC00000;  t_inv[8]=1; t_dz[8]=0;
    t_op[9]=2'b01;  t_a[9]=32'h80000000;  t_b[9]=32'h00000000;  t_sp[9]=1; t_res[9]=32'h80000000;  t_inv[9]=0; t_dz[9]=0;
    t_op[10]=2'b01; t_a[10]=32'h7F800000; t_b[10]=32'hFFFFFFFF; t_sp[10]=1; t_res[10]=32'h7F800000; t_inv[10]=0; t_dz[10]=0;
    for (int i = 0; i < 11; i++) begin
      issue(t_op[i], t_a[i], t_b[i], lat);
      total++; if (lat !== 2) $display("FAIL special[%0d] latency got %0d want 2", i, lat); else passed++;
      total++; if (out_special !== t_sp[i]) $display("FAIL special[%0d] special got %b want %b", i, out_special, t_sp[i]); else passed++;
      total++; if (out_special_res !== t_res[i]) $display("FAIL special[%0d] res got %h want %h", i, out_special_res, t_res[i]); else passed++;
      total++; if (out_invalid !== t_inv[i]) $display("FAIL special[%0d] invalid got %b want %b", i, out_invalid, t_inv[i]); else passed++;
      total++; if (out_divzero !== t_dz[i]) $display("FAIL special[%0d] divzero got %b want %b", i, out_divzero, t_dz[i]); else passed++;
    end
  endtask

  task automatic test_sqrt_subnormal();
    int lat;
    issue(2'b01, 32'h00000001, 32'hDEADBEEF, lat);
    total++; if (lat !== 2) $display("FAIL sqrt_sub latency got %0d want 2", lat); else passed++;
    total++; if (out_special !== 1'b0 || out_special_res !== 32'h0) $display("FAIL sqrt_sub special got %b/%h want 0/0", out_special, out_special_res); else passed++;
    total++; if (out_ea !== 8'h01) $display("FAIL sqrt_sub ea got %h want 01", out_ea); else passed++;
    total++; if (out_ma !== 24'h000001) $display("FAIL sqrt_sub ma got %h want 000001", out_ma); else passed++;
    total++; if (out_op !== 2'b01 || out_sign !== 1'b0) $display("FAIL sqrt_sub op/sign got %b/%b want 01/0", out_op, out_sign); else passed++;
  endtask

  task automatic test_reserved_op();
    int lat;
    issue(2'b10, 32'h3F800000, 32'h3F800000, lat);
    total++; if (lat !== 2) $display("FAIL reserved latency got %0d want 2", lat); else passed++;
    total++; if (out_special !== 1'b1 || out_special_res !== 32'h7FC00000) $display("FAIL reserved res got %b/%h want 1/7fc00000", out_special, out_special_res); else passed++;
    total++; if (out_invalid !== 1'b1 || out_divzero !== 1'b0) $display("FAIL reserved flags got %b%b want 10", out_invalid, out_divzero); else passed++;
    total++; if (out_op !== 2'b10) $display("FAIL reserved op got %b want 10", out_op); else passed++;
  endtask

  // Five divides 2^0..2^4 streamed back to back with out_ready following
  // 1,0,0,1,0,0,...; the scoreboard tracks occupancy to predict in_ready.
  task automatic test_back_to_back();
    int   sent, got, occ;
    logic prev_stall, acc, cons;
    logic [7:0] prev_ea;
    sent = 0; got = 0; occ = 0; prev_stall = 1'b0; prev_ea = '0;
    @(negedge clk);
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (prev_stall) begin
        total++; if (out_valid !== 1'b1 || out_ea !== prev_ea) $display("FAIL b2b hold c%0d got %b/%h want 1/%h", c, out_valid, out_ea, prev_ea); else passed++;
      end
      out_ready = (c % 3 == 0);
      in_valid  = (sent < 5);
      in_op     = 2'b00;
      in_a      = (sent < 5) ? 32'h3F800000 + sent * 32'h00800000 : 32'h0;
      in_b      = 32'h3F800000;
      #1;
      total++; if (in_ready !== !(occ == 2 && !out_ready)) $display("FAIL b2b in_ready c%0d got %b want %b", c, in_ready, !(occ == 2 && !out_ready)); else passed++;
      if (out_valid === 1'b1) begin
        total++;
        if (got >= 5) $display("FAIL b2b extra c%0d got ea %h want none", c, out_ea);
        else if (out_ea !== 8'h7F + 8'(got)) $display("FAIL b2b order c%0d got ea %h want %h", c, out_ea, 8'h7F + 8'(got));
        else passed++;
      end
      acc        = in_valid && in_ready;
      cons       = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      prev_ea    = out_ea;
      if (acc)  begin sent++; occ++; end
      if (cons) begin got++;  occ--; end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++; if (got !== 5 || sent !== 5) $display("FAIL b2b count got %0d/%0d want 5/5", got, sent); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL b2b drain got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_reset_midstream();
    int lat;
    out_ready = 1'b0;
    in_op     = 2'b00;
    in_b      = 32'h3F800000;
    in_a      = 32'h40000000;
    in_valid  = 1'b1;
    @(negedge clk);
    in_a = 32'h40800000;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL rst_mid full got %b/%b want 1/0", out_valid, in_ready); else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_mid out_valid got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_mid in_ready got %b want 1", in_ready); else passed++;
    out_ready = 1'b1;
    issue(2'b00, 32'h41000000, 32'h3F800000, lat);
    total++; if (lat !== 2) $display("FAIL rst_mid latency got %0d want 2", lat); else passed++;
    total++; if (out_ea !== 8'h82) $display("FAIL rst_mid ea got %h want 82", out_ea); else passed++;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL rst_mid stale got %b want 0", out_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_divide_normal();
    test_specials();
    test_sqrt_subnormal();
    test_reserved_op();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fp_operand_unpack.md
Name: fp_operand_unpack

Overview:
- Two-stage valid/ready front end for the divide/sqrt datapath: the unpacking side of the exponent/result path.
- Accepts packed IEEE-style operands and splits them into sign, biased exponent and mantissa with the hidden bit restored.
- Classifies special operands and resolves special-case results early, so the iterative core and the exponent logic only see finite nonzero work.
- Sits between the operand source and the exponent/mantissa datapath.

Parameters:
- EXP_W, 8, exponent field width; bias = 2**(EXP_W-1)-1.
- MAN_W, 23, stored fraction width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- in_op  in  2  00 = divide a/b, 01 = sqrt(a) (b ignored), 10/11 = reserved.
- in_a  in  EXP_W+MAN_W+1  packed operand a: {sign, exp, frac}.
- in_b  in  EXP_W+MAN_W+1  packed operand b.
- out_valid  out  1  unpacked result valid.
- out_ready  in  1  downstream accepts.
- out_op  out  2  in_op passthrough.
- out_sign  out  1  result sign.
- out_ea, out_eb  out  EXP_W  biased exponents for the exponent stage.
- out_ma, out_mb  out  MAN_W+1  mantissas with hidden bit.
- out_special  out  1  result already resolved; datapath must bypass the iteration.
- out_special_res  out  EXP_W+MAN_W+1  packed special result; all zeros when out_special=0.
- out_invalid, out_divzero  out  1  exception flags.

Behaviour:
- Reset (rst_n=0 at a clock edge): both stage valid bits cleared; out_valid=0; all data outputs 0; in_ready=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight entries; no output is produced for them.
- Stage S1 registers the raw inputs. Stage S2 registers the classified, unpacked fields.
- Transfer rules: an input is accepted when in_valid && in_ready; an output is consumed when out_valid && out_ready.
- Latency: 2 cycles from acceptance to out_valid with no stall. Throughput: 1 per cycle.
- s2_adv = !s2_valid || out_ready.
- s1_adv = s1_valid && s2_adv.
- in_ready = !s1_valid || s2_adv. in_ready is combinational from out_ready.
- Outputs hold stable while out_valid && !out_ready. No bubbles are inserted and none are lost under any stall pattern.
- Classification per operand, with exp field E and fraction F:
  - zero: E=0, F=0.
  - subnormal: E=0, F!=0.
  - inf: E all ones, F=0.
  - NaN: E all ones, F!=0.
  - Otherwise normal.
- Unpack:
  - normal: e = E, m = {1, F}.
  - subnormal: e = 1, m = {0, F}. No normalization is performed here.
  - zero, inf and NaN: e and m are driven but don't-care.
- out_sign: sign_a XOR sign_b for divide; sign_a for sqrt.
- qNaN = {0, all-ones exponent, 1 followed by zeros}.
- Divide specials, checked in this priority order:
  1. Any NaN operand, 0/0, or inf/inf -> qNaN, invalid=1.
  2. finite/0 -> inf with sign out_sign, divzero=1.
  3. inf/finite -> inf with sign out_sign.
  4. 0/nonzero or finite/inf -> zero with sign out_sign.
- Sqrt specials:
  - NaN -> qNaN, invalid=1.
  - Negative nonzero (including -inf) -> qNaN, invalid=1.
  - +-0 -> same-signed zero.
  - +inf -> +inf.
- Reserved op: out_special=1, qNaN, invalid=1.
- Flags are 0 whenever out_special=0. Flags are valid only while out_valid=1.

Test Plan:
- Divide, normal operands: op=00, a=0x40C00000 (6.0), b=0x40000000 (2.0) -> 2 cycles later out_valid=1, ea=0x81, eb=0x80, ma=0xC00000, mb=0x800000, sign=0, special=0.
- Divide by zero: op=00, a=0x3F800000, b=0x80000000 -> special=1, res=0xFF800000, divzero=1, invalid=0.
- Invalid divides: op=00 with 0/0 (0x00000000, 0x00000000) and inf/inf (0x7F800000, 0x7F800000) -> res=0x7FC00000, invalid=1 in both cases.
- Sqrt cases:
  - a=0xC0800000 (-4.0) -> qNaN, invalid=1.
  - a=0x80000000 -> res=0x80000000, invalid=0.
  - a=0x00000001 (subnormal) -> special=0, ea=0x01, ma=0x000001.
- Backpressure: stream 5 pairs back-to-back with out_ready toggling 1,0,0,1,... -> all 5 emerge in order, none dropped or duplicated, outputs stable while stalled, in_ready=0 exactly when both stages are full and out_ready=0.
- Reset mid-stream: drop rst_n for one edge with 2 entries in flight -> out_valid=0 and in_ready=1 the next cycle; a subsequent new input appears after 2 cycles.
